sim_memory_model_if_responder: RTL

- Memory-side endpoint of the simulation memory model interface.
- Drains request entries from the request sync FIFO's read side (first-word-fall-through: data valid whenever not empty).
- Executes each request against an internal word array after a programmable latency.
- Pushes read results into the response sync FIFO's write side. Provides the consumer end for the initiator's request queue and the producer end for its response queue.

---
 rtl/sim_memory_model_if_pkg.sv | 41 ++++
 rtl/sim_memory_model_if_ram.sv | 53 +++++
 rtl/sim_memory_model_if_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/sim_memory_model_if_pkg.sv
// rtl/sim_memory_model_if_pkg.sv - shared types, field layout helpers and byte merge for the memory model responder
package sim_memory_model_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int BYTE_N    = 8;
    localparam int WDATA_LSB = 0;

    // Request entry is {rw, mask, addr, wdata}; response entry is {is_ack, data}.
    function automatic int req_width(input int addr_n, input int data_n);
        return 1 + data_n / BYTE_N + addr_n + data_n;
    endfunction

    function automatic int addr_lsb(input int data_n);
        return data_n;
    endfunction

    function automatic int mask_lsb(input int addr_n, input int data_n);
        return data_n + addr_n;
    endfunction

    function automatic int rw_bit(input int addr_n, input int data_n);
        return data_n + addr_n + data_n / BYTE_N;
    endfunction

    function automatic int resp_width(input int data_n);
        return 1 + data_n;
    endfunction

    function automatic logic [BYTE_N-1:0] merge_byte(input logic [BYTE_N-1:0] old_b,
                                                     input logic [BYTE_N-1:0] new_b,
                                                     input logic              sel);
        return sel ? new_b : old_b;
    endfunction

endpackage

// File: rtl/sim_memory_model_if_ram.sv
// rtl/sim_memory_model_if_ram.sv - word array with byte-masked synchronous write and registered read
module sim_memory_model_if_ram
    import sim_memory_model_if_pkg::*;
#(
    parameter int ADDR_N = 10,
    parameter int DATA_N = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [DATA_N/8-1:0]      mask_i,
    input  logic [ADDR_N-1:0]        addr_i,
    input  logic [DATA_N-1:0]        wdata_i,
    output logic [DATA_N-1:0]        rdata_o
);

    logic [DATA_N-1:0] mem_q [2**ADDR_N];
    logic [DATA_N-1:0] old_w;
    logic [DATA_N-1:0] merged_w;
    logic [DATA_N-1:0] rdata_q;

    always_comb begin
        old_w = mem_q[addr_i];
    end

    always_comb begin
        merged_w = old_w;
        for (int i = 0; i < DATA_N / BYTE_N; i++) begin
            merged_w[i*BYTE_N +: BYTE_N] = merge_byte(old_w[i*BYTE_N +: BYTE_N],
                                                      wdata_i[i*BYTE_N +: BYTE_N], mask_i[i]);
        end
    end

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= merged_w;
        end
    end

    // A write also loads the merged word so it can be returned as a write ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? merged_w : old_w;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sim_memory_model_if_responder.sv
// rtl/sim_memory_model_if_responder.sv - memory-side request executor; SIM_MEMORY_MODEL_IF_WRITE_ACK_EN enables write acks
module sim_memory_model_if_responder
    import sim_memory_model_if_pkg::*;
#(
    parameter int ADDR_N  = 10,
    parameter int DATA_N  = 32,
    parameter int LATENCY = 2,
    parameter int CNT_N   = 4
) (
    input  logic                                    iCLOCK,
    input  logic                                    iRESET_SYNC,
    input  logic                                    iREMOVE,
    output logic                                    oBUSY,
    input  logic                                    iREQ_EMPTY,
    input  logic [req_width(ADDR_N, DATA_N)-1:0]    iREQ_DATA,
    output logic                                    oREQ_RD_EN,
    input  logic                                    iRESP_FULL,
    output logic                                    oRESP_WR_EN,
    output logic [resp_width(DATA_N)-1:0]           oRESP_WR_DATA
);

    localparam int REQ_W    = req_width(ADDR_N, DATA_N);
    localparam int ADDR_LSB = addr_lsb(DATA_N);
    localparam int MASK_LSB = mask_lsb(ADDR_N, DATA_N);
    localparam int RW_BIT   = rw_bit(ADDR_N, DATA_N);

    state_e             state_q, state_d;
    logic [CNT_N-1:0]   cnt_q, cnt_d;
    logic [REQ_W-1:0]   req_q, req_d;
    logic               accept;
    logic               req_rw;
    logic [DATA_N-1:0]  rdata;
    logic               ack_bit;

    assign req_rw = req_q[RW_BIT];
    assign accept = (state_q == IDLE) && !iREQ_EMPTY && !iREMOVE && !iRESET_SYNC;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d   = iREQ_DATA;
                    cnt_d   = CNT_N'(LATENCY);
                    state_d = (LATENCY == 0) ? EXEC : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_N'(1)) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifdef SIM_MEMORY_MODEL_IF_WRITE_ACK_EN
                state_d = RESP;
`else
                state_d = req_rw ? IDLE : RESP;
`endif
            end
            RESP: begin
                if (!iRESP_FULL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over accept and push; an EXEC write still lands in the array.
        if (iREMOVE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        oBUSY       = (state_q != IDLE);
        oREQ_RD_EN  = accept;
        oRESP_WR_EN = (state_q == RESP) && !iRESP_FULL && !iREMOVE;
    end

`ifdef SIM_MEMORY_MODEL_IF_WRITE_ACK_EN
    assign ack_bit = req_rw;
`else
    assign ack_bit = 1'b0;
`endif

    assign oRESP_WR_DATA = {ack_bit, rdata};

    sim_memory_model_if_ram #(
        .ADDR_N (ADDR_N),
        .DATA_N (DATA_N)
    ) u_ram (
        .clk_i   (iCLOCK),
        .rst_i   (iRESET_SYNC),
        .en_i    ((state_q == EXEC) && !iRESET_SYNC),
        .we_i    (req_rw),
        .mask_i  (req_q[MASK_LSB +: DATA_N/8]),
        .addr_i  (req_q[ADDR_LSB +: ADDR_N]),
        .wdata_i (req_q[WDATA_LSB +: DATA_N]),
        .rdata_o (rdata)
    );

endmodule
